// File: rtl/jk_excitation_driver.sv
// Drives J/K excitation into a JK flip-flop bank until its Q matches a target.
// One-cycle drive, readback compare with timeout, bounded re-drive, done/err pulse.
module jk_excitation_driver #(
    parameter int WIDTH       = 8,
    parameter int MODE_TOGGLE = 0,
    parameter int TIMEOUT     = 4,
    parameter int MAX_RETRY   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    input  logic [WIDTH-1:0] tgt_data,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] tgt_nxt;
    logic [WIDTH-1:0] j_nxt;
    logic [WIDTH-1:0] k_nxt;
    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] diff;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [RW-1:0]    retry;
    logic [RW-1:0]    retry_nxt;
    logic             done_nxt;
    logic             err_nxt;
    logic             accept;
    logic             match;
    logic             expired;
    logic             can_retry;

    assign accept    = tgt_valid && (state == IDLE);
    assign match     = (q_fb == tgt);
    assign expired   = (cnt == CNT_LAST);
    assign can_retry = (retry < RETRY_MAX);

    assign busy      = (state != IDLE);
    assign tgt_ready = (state == IDLE);

    // A fresh accept excites toward the incoming word; a retry uses the held target.
    assign exc_tgt = (state == IDLE) ? tgt_data : tgt;
    assign diff    = q_fb ^ exc_tgt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                if (match) begin
                    state_nxt = IDLE;
                end else if (expired) begin
                    state_nxt = can_retry ? DRIVE : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        j_nxt     = '0;
        k_nxt     = '0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        tgt_nxt   = tgt;
        cnt_nxt   = cnt;
        retry_nxt = retry;

        // Excitation lives only in the DRIVE cycle; unchanged bits hold.
        if (state_nxt == DRIVE) begin
            if (MODE_TOGGLE != 0) begin
                j_nxt = diff;
                k_nxt = diff;
            end else begin
                j_nxt = diff & exc_tgt;
                k_nxt = diff & ~exc_tgt;
            end
        end

        unique case (state)
            IDLE: begin
                if (accept) begin
                    tgt_nxt   = tgt_data;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            CHECK: begin
                if (match) begin
                    done_nxt = 1'b1;
                end else if (expired) begin
                    cnt_nxt = '0;
                    if (can_retry) begin
                        retry_nxt = retry + 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
            tgt   <= '0;
            cnt   <= '0;
            retry <= '0;
        end else begin
            j     <= j_nxt;
            k     <= k_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            tgt   <= tgt_nxt;
            cnt   <= cnt_nxt;
            retry <= retry_nxt;
        end
    end

endmodule
